// File: rtl/otp_pad_scheduler.sv
// Sequencing controller for the one-time-pad datapath: arbitrates encrypt/decrypt
// requests, tracks which pad slots hold an unused pad, and issues one command at a time.
module otp_pad_scheduler #(
    parameter int SLOTS = 8,
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             enc_req,
    output logic             enc_ack,
    output logic [IDX_W-1:0] enc_slot,
    output logic             enc_err,
    input  logic             dec_req,
    input  logic [IDX_W-1:0] dec_slot,
    output logic             dec_ack,
    output logic             dec_err,
    output logic             dp_valid,
    output logic             dp_decrypt,
    output logic [IDX_W-1:0] dp_idx,
    output logic [IDX_W:0]   free_cnt,
    output logic             full,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t           state, state_next;
    logic [SLOTS-1:0] vld, vld_next;
    logic             last_dec;
    logic             op_dec, op_err;
    logic [IDX_W-1:0] op_idx;

    logic             grant, pick_dec, grant_err;
    logic [IDX_W-1:0] grant_idx, free_idx;
    logic             op_dec_nx, op_err_nx;
    logic [IDX_W-1:0] op_idx_nx;
    logic [IDX_W:0]   used, free_next;

    logic             enc_ack_d, enc_err_d, dec_ack_d, dec_err_d;
    logic             dp_valid_d, dp_decrypt_d, busy_d;
    logic [IDX_W-1:0] enc_slot_d, dp_idx_d;

    // Lowest-numbered empty slot; scanning downward lets the smallest index win.
    always_comb begin
        free_idx = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!vld[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        pick_dec   = 1'b0;
        grant_err  = 1'b0;
        grant_idx  = '0;
        case (state)
            IDLE: begin
                if (ena && (enc_req || dec_req)) begin
                    grant    = 1'b1;
                    pick_dec = dec_req && (!enc_req || !last_dec);
                    if (pick_dec) begin
                        grant_idx = dec_slot;
                        grant_err = !vld[dec_slot];
                    end else begin
                        grant_idx = free_idx;
                        grant_err = &vld;
                    end
                    state_next = grant_err ? ACK : ISSUE;
                end
            end
            ISSUE:   state_next = WAIT;
            WAIT:    state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The bitmap changes on the edge that ends ISSUE, so the pad count follows it directly.
    always_comb begin
        vld_next = vld;
        if (state == ISSUE) vld_next[op_idx] = !op_dec;
        used = '0;
        for (int i = 0; i < SLOTS; i++) begin
            used = used + (IDX_W + 1)'(vld_next[i]);
        end
        free_next = (IDX_W + 1)'(SLOTS) - used;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            vld      <= '0;
            last_dec <= 1'b1;
            op_dec   <= 1'b0;
            op_err   <= 1'b0;
            op_idx   <= '0;
            free_cnt <= (IDX_W + 1)'(SLOTS);
            full     <= 1'b0;
        end else begin
            state    <= state_next;
            vld      <= vld_next;
            free_cnt <= free_next;
            full     <= (free_next == '0);
            if (grant) begin
                last_dec <= pick_dec;
                op_dec   <= pick_dec;
                op_err   <= grant_err;
                op_idx   <= grant_idx;
            end
        end
    end

    // Outputs are computed from the upcoming state so every strobe comes straight from a flop.
    always_comb begin
        op_dec_nx    = grant ? pick_dec  : op_dec;
        op_err_nx    = grant ? grant_err : op_err;
        op_idx_nx    = grant ? grant_idx : op_idx;
        dp_valid_d   = (state_next == ISSUE);
        dp_decrypt_d = dp_valid_d ? op_dec_nx : dp_decrypt;
        dp_idx_d     = dp_valid_d ? op_idx_nx : dp_idx;
        enc_ack_d    = (state_next == ACK) && !op_dec_nx;
        enc_err_d    = enc_ack_d && op_err_nx;
        enc_slot_d   = enc_ack_d ? op_idx_nx : enc_slot;
        dec_ack_d    = (state_next == ACK) && op_dec_nx;
        dec_err_d    = dec_ack_d && op_err_nx;
        busy_d       = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enc_ack    <= 1'b0;
            enc_err    <= 1'b0;
            enc_slot   <= '0;
            dec_ack    <= 1'b0;
            dec_err    <= 1'b0;
            dp_valid   <= 1'b0;
            dp_decrypt <= 1'b0;
            dp_idx     <= '0;
            busy       <= 1'b0;
        end else begin
            enc_ack    <= enc_ack_d;
            enc_err    <= enc_err_d;
            enc_slot   <= enc_slot_d;
            dec_ack    <= dec_ack_d;
            dec_err    <= dec_err_d;
            dp_valid   <= dp_valid_d;
            dp_decrypt <= dp_decrypt_d;
            dp_idx     <= dp_idx_d;
            busy       <= busy_d;
        end
    end

endmodule

// File: tb/tb_otp_pad_scheduler.sv
// Self-checking bench for otp_pad_scheduler: directed scenarios plus random request
// mixes, all compared against a transaction-level model of the pad bitmap.
module tb_otp_pad_scheduler;

    logic       clk, rst, ena;
    logic       enc_req, enc_ack, enc_err;
    logic [2:0] enc_slot;
    logic       dec_req, dec_ack, dec_err;
    logic [2:0] dec_slot;
    logic       dp_valid, dp_decrypt;
    logic [2:0] dp_idx;
    logic [3:0] free_cnt;
    logic       full, busy;

    int vectors = 0;
    int miscompares = 0;

    bit m_vld[8];
    bit m_last_dec;

    otp_pad_scheduler #(.SLOTS(8), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .enc_req(enc_req), .enc_ack(enc_ack), .enc_slot(enc_slot), .enc_err(enc_err),
        .dec_req(dec_req), .dec_slot(dec_slot), .dec_ack(dec_ack), .dec_err(dec_err),
        .dp_valid(dp_valid), .dp_decrypt(dp_decrypt), .dp_idx(dp_idx),
        .free_cnt(free_cnt), .full(full), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic int m_lowest_free();
        for (int i = 0; i < 8; i++) if (!m_vld[i]) return i;
        return -1;
    endfunction

    function automatic int m_free();
        int n = 0;
        for (int i = 0; i < 8; i++) if (!m_vld[i]) n++;
        return n;
    endfunction

    task automatic do_reset();
        rst = 1'b1; ena = 1'b1; enc_req = 1'b0; dec_req = 1'b0; dec_slot = 3'd0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) m_vld[i] = 1'b0;
        m_last_dec = 1'b1;
    endtask

    // One granted transaction: raise requests, follow it to its ack, check timing and result.
    task automatic txn(input bit e, input bit d, input int s, input bit drop_ena,
                       output bit won_dec, output int wait_cyc);
        bit exp_dec, exp_err, got_dec, got_err, dpv_dec, both_acks;
        int exp_idx, ack_c, dpv_c, dpv_n, dpv_idx, got_slot;
        exp_dec = d && (!e || !m_last_dec);
        if (exp_dec) begin
            exp_idx = s;
            exp_err = !m_vld[s];
        end else begin
            exp_idx = m_lowest_free();
            exp_err = (exp_idx < 0);
        end
        enc_req = e; dec_req = d; dec_slot = 3'(s);
        wait_cyc = 0;
        do begin
            @(posedge clk); @(negedge clk);
            wait_cyc++;
        end while (busy !== 1'b1 && wait_cyc < 20);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL grant_timeout: busy=%b after %0d cycles, required 1", busy, wait_cyc);
        end
        ack_c = 0; dpv_n = 0; dpv_c = 0; dpv_dec = 0; dpv_idx = 0;
        got_dec = 0; got_err = 0; got_slot = 0; both_acks = 0;
        for (int c = 1; c <= 8 && ack_c == 0; c++) begin
            if (c > 1) begin @(posedge clk); @(negedge clk); end
            if (dp_valid === 1'b1) begin
                dpv_n++; dpv_c = c; dpv_dec = dp_decrypt; dpv_idx = int'(dp_idx);
            end
            if (enc_ack === 1'b1 || dec_ack === 1'b1) begin
                ack_c = c;
                got_dec = (dec_ack === 1'b1);
                both_acks = (enc_ack === 1'b1) && (dec_ack === 1'b1);
                got_err = got_dec ? dec_err : enc_err;
                got_slot = int'(enc_slot);
                if (got_dec) dec_req = 1'b0; else enc_req = 1'b0;
            end
            if (drop_ena && c == 2) ena = 1'b0;
        end
        won_dec = got_dec;
        if (!exp_err) m_vld[exp_idx] = !exp_dec;
        m_last_dec = exp_dec;

        vectors++;
        if (ack_c == 0) begin
            miscompares++;
            $display("[TB] FAIL ack_timeout: no ack within 8 cycles, required one");
        end
        vectors++;
        if (both_acks) begin
            miscompares++;
            $display("[TB] FAIL dual_ack: enc_ack and dec_ack both high, required one");
        end
        vectors++;
        if (got_dec !== exp_dec) begin
            miscompares++;
            $display("[TB] FAIL winner: got dec=%b, required dec=%b", got_dec, exp_dec);
        end
        vectors++;
        if (ack_c !== (exp_err ? 1 : 3)) begin
            miscompares++;
            $display("[TB] FAIL ack_cycle: ack at T+%0d, required T+%0d", ack_c, exp_err ? 1 : 3);
        end
        vectors++;
        if (got_err !== exp_err) begin
            miscompares++;
            $display("[TB] FAIL err: got %b, required %b", got_err, exp_err);
        end
        vectors++;
        if (dpv_n !== (exp_err ? 0 : 1)) begin
            miscompares++;
            $display("[TB] FAIL dp_valid_count: got %0d, required %0d", dpv_n, exp_err ? 0 : 1);
        end
        if (dpv_n == 1) begin
            vectors++;
            if (dpv_c !== 1 || dpv_dec !== exp_dec || dpv_idx !== exp_idx) begin
                miscompares++;
                $display("[TB] FAIL dp_cmd: cycle=%0d dec=%b idx=%0d, required cycle=1 dec=%b idx=%0d",
                         dpv_c, dpv_dec, dpv_idx, exp_dec, exp_idx);
            end
        end
        if (!exp_dec && !exp_err) begin
            vectors++;
            if (got_slot !== exp_idx) begin
                miscompares++;
                $display("[TB] FAIL enc_slot: got %0d, required %0d", got_slot, exp_idx);
            end
        end
        vectors++;
        if (int'(free_cnt) !== m_free() || full !== (m_free() == 0)) begin
            miscompares++;
            $display("[TB] FAIL free_cnt: got %0d full=%b, required %0d full=%b",
                     free_cnt, full, m_free(), m_free() == 0);
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({enc_ack, enc_err, enc_slot, dec_ack, dec_err, dp_valid, dp_decrypt, dp_idx, full, busy} !== 14'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got %b, required all zero",
                     {enc_ack, enc_err, enc_slot, dec_ack, dec_err, dp_valid, dp_decrypt, dp_idx, full, busy});
        end
        vectors++;
        if (free_cnt !== 4'd8) begin
            miscompares++;
            $display("[TB] FAIL reset_free_cnt: got %0d, required 8", free_cnt);
        end
    endtask

    task automatic test_fill_wrap();
        bit w; int wc;
        do_reset();
        for (int i = 0; i < 9; i++) txn(1, 0, 0, 0, w, wc);
    endtask

    task automatic test_decrypt_reuse();
        bit w; int wc;
        do_reset();
        for (int i = 0; i < 3; i++) txn(1, 0, 0, 0, w, wc);
        txn(0, 1, 1, 0, w, wc);
        txn(0, 1, 1, 0, w, wc);
        txn(1, 0, 0, 0, w, wc);
    endtask

    task automatic test_dec_invalid();
        bit w; int wc;
        do_reset();
        txn(0, 1, 5, 0, w, wc);
    endtask

    task automatic test_arbitration();
        bit w; int wc;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            txn(1, 1, 0, 0, w, wc);
            vectors++;
            if (w !== bit'(i % 2)) begin
                miscompares++;
                $display("[TB] FAIL alternation: grant %0d dec=%b, required dec=%b", i, w, bit'(i % 2));
            end
        end
        enc_req = 1'b0; dec_req = 1'b0;
    endtask

    task automatic test_ena();
        bit w; int wc;
        do_reset();
        ena = 1'b0; enc_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || enc_ack !== 1'b0 || dp_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL ena_block: busy=%b ack=%b dp_valid=%b, required 0 0 0", busy, enc_ack, dp_valid);
            end
        end
        ena = 1'b1;
        txn(1, 0, 0, 0, w, wc);
        vectors++;
        if (wc !== 1) begin
            miscompares++;
            $display("[TB] FAIL ena_grant_latency: %0d cycles, required 1", wc);
        end
        txn(1, 0, 0, 1, w, wc);
        ena = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        bit w; int wc, n;
        do_reset();
        txn(1, 0, 0, 0, w, wc);
        txn(1, 0, 0, 0, w, wc);
        enc_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk); @(negedge clk);
            n++;
        end while (dp_valid !== 1'b1 && n < 10);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0; enc_req = 1'b0;
        for (int i = 0; i < 8; i++) m_vld[i] = 1'b0;
        m_last_dec = 1'b1;
        vectors++;
        if (n >= 10 || busy !== 1'b0 || free_cnt !== 4'd8 || full !== 1'b0 || dp_valid !== 1'b0 || enc_ack !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL mid_op_reset: n=%0d busy=%b free=%0d full=%b dpv=%b ack=%b, required busy=0 free=8 0 0 0",
                     n, busy, free_cnt, full, dp_valid, enc_ack);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if (enc_ack !== 1'b0 || dp_valid !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL aborted_ack: ack=%b dp_valid=%b, required 0 0", enc_ack, dp_valid);
            end
        end
        txn(1, 0, 0, 0, w, wc);
    endtask

    task automatic test_random();
        bit pend_e, pend_d, w; int slot, wc;
        do_reset();
        pend_e = 0; pend_d = 0; slot = 0;
        for (int i = 0; i < 60; i++) begin
            if (!pend_e) pend_e = bit'($urandom % 2);
            if (!pend_d) begin
                pend_d = bit'($urandom % 2);
                if (pend_d) slot = int'($urandom % 8);
            end
            if (!pend_e && !pend_d) pend_e = 1'b1;
            txn(pend_e, pend_d, slot, 0, w, wc);
            if (w) pend_d = 1'b0; else pend_e = 1'b0;
        end
        enc_req = 1'b0; dec_req = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; enc_req = 1'b0; dec_req = 1'b0; dec_slot = 3'd0;
        test_reset();
        test_fill_wrap();
        test_decrypt_reuse();
        test_dec_invalid();
        test_arbitration();
        test_ena();
        test_reset_mid_op();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/otp_pad_scheduler.md
# otp_pad_scheduler

Sequencing controller for the one-time-pad encrypt/decrypt datapath. Arbitrates between an encrypt requester and a decrypt requester, allocates and retires the 8 pad slots so each pad is used for exactly one decryption, and issues single-cycle command strobes to the datapath. It sits between the host-side request logic and the pad memory / XOR datapath, so the datapath never sees overlapping or illegal operations.

## Interface

Parameters:
- SLOTS, 8, number of pad slots; power of two.
- IDX_W, 3, slot index width; log2(SLOTS).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  enable; low blocks new grants, in-flight op completes.
- enc_req  in  1  encrypt request; held until enc_ack.
- enc_ack  out  1  one-cycle encrypt completion pulse.
- enc_slot  out  IDX_W  slot allocated to this encryption; valid with enc_ack.
- enc_err  out  1  with enc_ack: no free slot, nothing issued.
- dec_req  in  1  decrypt request; held until dec_ack.
- dec_slot  in  IDX_W  slot to decrypt with; stable while dec_req is high.
- dec_ack  out  1  one-cycle decrypt completion pulse.
- dec_err  out  1  with dec_ack: slot not valid (never written or already consumed), nothing issued.
- dp_valid  out  1  one-cycle command strobe to datapath.
- dp_decrypt  out  1  command type; 1 = decrypt (read pad), 0 = encrypt (write pad).
- dp_idx  out  IDX_W  pad memory index for the command.
- free_cnt  out  IDX_W+1  number of free slots, 0..SLOTS.
- full  out  1  free_cnt == 0.
- busy  out  1  state != IDLE.

## Operation

- State: slot valid bitmap `vld[SLOTS-1:0]`, round-robin flag `last_dec`, FSM {IDLE, ISSUE, WAIT, ACK}, latched op type, index and error.
- IDLE, ena=1, at least one req: select winner. Only one requesting: it wins. Both: the one not served last wins (`last_dec=1` → encrypt wins). Update `last_dec` on every grant, including error grants.
- Encrypt grant: if full → enc_err=1, go to ACK. Else index = lowest i with vld[i]=0, go to ISSUE.
- Decrypt grant: if vld[dec_slot]=0 → dec_err=1, go to ACK. Else index = dec_slot, go to ISSUE.
- ISSUE: dp_valid=1, dp_decrypt and dp_idx driven. Encrypt sets vld[idx]; decrypt clears vld[idx] (pad retired). Next: WAIT.
- WAIT: one cycle for the registered datapath output. Next: ACK.
- ACK: matching ack=1 for one cycle with enc_slot/err. Next: IDLE.
- Requesters clear req on the edge that samples ack, so req is low in the following IDLE cycle.
- ena=0 in IDLE: stay IDLE, no grant. ena=0 in other states: no effect, op completes.
- free_cnt = SLOTS − popcount(vld), registered, updated the cycle after ISSUE. full follows free_cnt.
- Only one op is in flight at a time; no read/write hazards on a slot.

## Timing

- Reset (rst=1 at an edge): state IDLE, vld=0, last_dec=1, all acks/errs/dp_valid=0, dp_decrypt=0, dp_idx=0, enc_slot=0, free_cnt=SLOTS, full=0, busy=0. Reset mid-op aborts: no ack, no strobe, bitmap cleared.
- All outputs are registered.
- Normal op: req sampled in IDLE at edge T → dp_valid high in cycle T+1 → WAIT T+2 → ack high T+3 → IDLE T+4. One op per 4 cycles.
- Error op: req sampled at T → ack+err high T+1 → IDLE T+2. dp_valid is never asserted.
- dp_valid is high for exactly one cycle per successful op. Ack is high for exactly one cycle per grant.
- Wrap: after all SLOTS encryptions without decryption, the next encrypt errors. After any decrypt, that slot is reused by the next encrypt, lowest index first.

## Test plan

- Reset, then 8 back-to-back encrypts → enc_slot 0,1,…,7, each ack 3 cycles after grant, free_cnt 8→0, full=1. 9th encrypt → enc_err=1 at T+1, no dp_valid.
- Encrypt ×3 (slots 0–2), decrypt slot 1 → dp_valid with dp_decrypt=1, dp_idx=1, dec_err=0, free_cnt 5→6. Decrypt slot 1 again → dec_err=1. Next encrypt → enc_slot=1.
- Decrypt slot 5 right after reset → dec_ack with dec_err=1 one cycle after sampling, vld unchanged, free_cnt=8.
- enc_req and dec_req both held high continuously, with valid slots available → grants alternate enc, dec, enc, dec. First grant after reset is encrypt.
- ena=0 with enc_req=1 for 5 cycles → no grant, busy=0. Raise ena → grant the next cycle. Drop ena during WAIT → ack still arrives on schedule.
- Assert rst during ISSUE of an encrypt → no ack. Following cycle: free_cnt=8, busy=0. A subsequent encrypt gets enc_slot=0.
